// File: rtl/sr_event_decoder.sv
// sr_event_decoder: decodes a level input into debounced set/reset event pulses
//   Clk     - system clock, rising edge
//   Rst     - synchronous reset, active-high
//   Din     - asynchronous level input
//   Q       - debounced level of Din
//   S / R   - one-cycle pulse on each accepted rise / fall
//   Glitch  - one-cycle pulse when a candidate transition is abandoned
//   RiseCnt - saturating count of S pulses
//   FallCnt - saturating count of R pulses
module sr_event_decoder #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Din,
    output logic             Q,
    output logic             S,
    output logic             R,
    output logic             Glitch,
    output logic [CNT_W-1:0] RiseCnt,
    output logic [CNT_W-1:0] FallCnt
);
    if (DEBOUNCE < 2 || DEBOUNCE > 255) begin : g_bad_debounce
        $error("sr_event_decoder: DEBOUNCE=%0d outside 2..255", DEBOUNCE);
    end

    localparam logic [7:0] LAST = 8'(DEBOUNCE - 1);

    typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [7:0]       cnt_q, cnt_d;
    logic             q_q, q_d, s_q, s_d, r_q, r_d, g_q, g_d;
    logic [CNT_W-1:0] rise_q, rise_d, fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        g_d     = 1'b0;
        rise_d  = rise_q;
        fall_d  = fall_q;
        case (state_q)
            LOW: if (sync2_q) begin
                state_d = RISE_WAIT;
                cnt_d   = 8'd1;
            end
            RISE_WAIT: if (!sync2_q) begin
                state_d = LOW;
                g_d     = 1'b1;
            end else if (cnt_q == LAST) begin
                state_d = HIGH;
                q_d     = 1'b1;
                s_d     = 1'b1;
                rise_d  = (rise_q == '1) ? rise_q : rise_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            HIGH: if (!sync2_q) begin
                state_d = FALL_WAIT;
                cnt_d   = 8'd1;
            end
            FALL_WAIT: if (sync2_q) begin
                state_d = HIGH;
                g_d     = 1'b1;
            end else if (cnt_q == LAST) begin
                state_d = LOW;
                q_d     = 1'b0;
                r_d     = 1'b1;
                fall_d  = (fall_q == '1) ? fall_q : fall_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            default: state_d = LOW;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= LOW;
            cnt_q   <= 8'd0;
            q_q     <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            g_q     <= 1'b0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync1_q <= Din;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            s_q     <= s_d;
            r_q     <= r_d;
            g_q     <= g_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign Q       = q_q;
    assign S       = s_q;
    assign R       = r_q;
    assign Glitch  = g_q;
    assign RiseCnt = rise_q;
    assign FallCnt = fall_q;
endmodule

// File: tb/tb_sr_event_decoder.sv
// tb_sr_event_decoder: randomized and directed checks of sr_event_decoder against a run-length model
module tb_sr_event_decoder;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       q, s, r, g;
    logic [7:0] rc, fc;

    int total = 0;
    int bad   = 0;

    // reference model: samples delayed two edges, then a run length of
    // consecutive samples disagreeing with the accepted level
    logic samp[$];
    logic acc;
    int   run;
    logic m_s, m_r, m_g;
    int   m_rc, m_fc;

    always #5 clk = ~clk;

    sr_event_decoder #(.DEBOUNCE(D), .CNT_W(8)) dut (
        .Clk(clk), .Rst(rst), .Din(din), .Q(q), .S(s), .R(r),
        .Glitch(g), .RiseCnt(rc), .FallCnt(fc)
    );

    task automatic tick(input logic d, input logic rs);
        logic v;
        din = d;
        rst = rs;
        @(posedge clk);
        m_s = 1'b0;
        m_r = 1'b0;
        m_g = 1'b0;
        if (rs) begin
            samp = '{1'b0, 1'b0};
            acc  = 1'b0;
            run  = 0;
            m_rc = 0;
            m_fc = 0;
        end else begin
            v = samp.pop_front();
            samp.push_back(d);
            if (v != acc) begin
                run++;
                if (run == D) begin
                    acc = v;
                    run = 0;
                    if (v) begin
                        m_s  = 1'b1;
                        m_rc = (m_rc == 255) ? 255 : m_rc + 1;
                    end else begin
                        m_r  = 1'b1;
                        m_fc = (m_fc == 255) ? 255 : m_fc + 1;
                    end
                end
            end else begin
                if (run > 0) m_g = 1'b1;
                run = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1);
        total++;
        if ({q, s, r, g, rc, fc} !== 20'd0) begin
            bad++;
            $display("FAIL reset_state got q=%b s=%b r=%b g=%b rise=%0d fall=%0d want all 0", q, s, r, g, rc, fc);
        end
        tick(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            total++;
            if ({q, s, r, g, rc, fc} !== 20'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got q=%b s=%b r=%b g=%b rise=%0d fall=%0d want all 0", i, q, s, r, g, rc, fc);
            end
        end
    endtask

    task automatic test_rise_fall();
        int ns = 0, nr = 0;
        for (int i = 0; i < 40; i++) begin
            tick(i < 20, 1'b0);
            ns += s;
            nr += r;
            total++;
            if ({q, s, r, g, rc, fc} !== {acc, m_s, m_r, m_g, 8'(m_rc), 8'(m_fc)}) begin
                bad++;
                $display("FAIL rise_fall cyc=%0d got q=%b s=%b r=%b g=%b rise=%0d fall=%0d want q=%b s=%b r=%b g=%b rise=%0d fall=%0d",
                         i, q, s, r, g, rc, fc, acc, m_s, m_r, m_g, m_rc, m_fc);
            end
        end
        total++;
        if (ns != 1 || nr != 1 || rc !== 8'd1 || fc !== 8'd1) begin
            bad++;
            $display("FAIL rise_fall_counts got s=%0d r=%0d rise=%0d fall=%0d want 1 1 1 1", ns, nr, rc, fc);
        end
    endtask

    task automatic test_glitch();
        int ng = 0, nsr = 0;
        logic [7:0] rc0 = rc, fc0 = fc;
        // pulse high while low, settle high, pulse low while high
        for (int i = 0; i < 52; i++) begin
            tick((i < 2) || (i >= 12 && i < 40) || (i >= 42), 1'b0);
            if (i < 12 || i >= 40) begin
                ng  += g;
                nsr += s + r;
            end
            total++;
            if ({q, s, r, g, rc, fc} !== {acc, m_s, m_r, m_g, 8'(m_rc), 8'(m_fc)}) begin
                bad++;
                $display("FAIL glitch cyc=%0d got q=%b s=%b r=%b g=%b rise=%0d fall=%0d want q=%b s=%b r=%b g=%b rise=%0d fall=%0d",
                         i, q, s, r, g, rc, fc, acc, m_s, m_r, m_g, m_rc, m_fc);
            end
        end
        total++;
        if (ng != 2 || nsr != 0 || q !== 1'b1 || rc !== rc0 + 8'd1 || fc !== fc0) begin
            bad++;
            $display("FAIL glitch_summary got glitches=%0d edges=%0d q=%b rise=%0d fall=%0d want 2 0 1 %0d %0d",
                     ng, nsr, q, rc, fc, rc0 + 8'd1, fc0);
        end
    endtask

    task automatic test_saturation();
        int ns = 0, nr = 0;
        for (int p = 0; p < 300; p++) begin
            for (int i = 0; i < 20; i++) begin
                tick(i >= 10, 1'b0);
                if (p >= 290) begin
                    ns += s;
                    nr += r;
                end
                total++;
                if ({q, s, r, g, rc, fc} !== {acc, m_s, m_r, m_g, 8'(m_rc), 8'(m_fc)}) begin
                    bad++;
                    $display("FAIL saturation p=%0d cyc=%0d got q=%b s=%b r=%b g=%b rise=%0d fall=%0d want q=%b s=%b r=%b g=%b rise=%0d fall=%0d",
                             p, i, q, s, r, g, rc, fc, acc, m_s, m_r, m_g, m_rc, m_fc);
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
            nr += r;
        end
        total++;
        if (rc !== 8'd255 || fc !== 8'd255 || ns < 9 || nr < 9) begin
            bad++;
            $display("FAIL saturation_end got rise=%0d fall=%0d s=%0d r=%0d want 255 255 >=9 >=9", rc, fc, ns, nr);
        end
    endtask

    task automatic test_reset_abort();
        int at = -1;
        // five edges bring the FSM to RISE_WAIT with cnt=3; reset lands on the sixth
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        total++;
        if (s !== 1'b0 || q !== 1'b0 || g !== 1'b0 || rc !== 8'd0 || fc !== 8'd0) begin
            bad++;
            $display("FAIL reset_abort got s=%b q=%b g=%b rise=%0d fall=%0d want 0 0 0 0 0", s, q, g, rc, fc);
        end
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 1'b0);
            if (s === 1'b1 && at < 0) at = i;
            total++;
            if ({q, s, r, g, rc, fc} !== {acc, m_s, m_r, m_g, 8'(m_rc), 8'(m_fc)}) begin
                bad++;
                $display("FAIL reset_abort_after cyc=%0d got q=%b s=%b r=%b g=%b rise=%0d fall=%0d want q=%b s=%b r=%b g=%b rise=%0d fall=%0d",
                         i, q, s, r, g, rc, fc, acc, m_s, m_r, m_g, m_rc, m_fc);
            end
        end
        total++;
        if (at != 6 || rc !== 8'd1) begin
            bad++;
            $display("FAIL reset_abort_latency got s_edge=%0d rise=%0d want 6 1", at, rc);
        end
    endtask

    task automatic test_reset_high();
        int at = -1, ns = 0, ng = 0;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            tick(1'b1, 1'b0);
            if (s === 1'b1 && at < 0) at = i;
            ns += s;
            ng += g;
        end
        total++;
        if (at != 6 || ns != 1 || ng != 0 || q !== 1'b1 || rc !== 8'd1) begin
            bad++;
            $display("FAIL reset_high got s_edge=%0d s=%0d g=%0d q=%b rise=%0d want 6 1 0 1 1", at, ns, ng, q, rc);
        end
    endtask

    task automatic test_random();
        logic d = 1'b0;
        int   left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (left == 0) begin
                d    = $urandom_range(1, 0);
                left = $urandom_range(8, 1);
            end
            left--;
            tick(d, $urandom_range(199, 0) == 0);
            total++;
            if ({q, s, r, g, rc, fc} !== {acc, m_s, m_r, m_g, 8'(m_rc), 8'(m_fc)} ||
                (s & r) || (g & (s | r))) begin
                bad++;
                $display("FAIL random cyc=%0d got q=%b s=%b r=%b g=%b rise=%0d fall=%0d want q=%b s=%b r=%b g=%b rise=%0d fall=%0d",
                         i, q, s, r, g, rc, fc, acc, m_s, m_r, m_g, m_rc, m_fc);
            end
        end
    endtask

    initial begin
        samp = '{1'b0, 1'b0};
        acc  = 1'b0;
        run  = 0;
        m_rc = 0;
        m_fc = 0;
        test_reset();
        test_rise_fall();
        test_glitch();
        test_saturation();
        test_reset_abort();
        test_reset_high();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
